// File: rtl/router_fsm_multi.sv
// Ingress control FSM for a 1xN router: header decode, payload/parity load, full stall,
// parity check, per-destination soft reset, out-of-range drop and WAIT_TILL_EMPTY timeout.
module router_fsm_multi #(
    parameter int NUM_DEST = 3,
    parameter int ADDR_W   = 2,
    parameter int WAIT_TO  = 0,
    parameter int TO_W     = 16
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                pkt_valid,
    input  logic [ADDR_W-1:0]   data_in,
    input  logic                fifo_full,
    input  logic [NUM_DEST-1:0] fifo_empty,
    input  logic [NUM_DEST-1:0] soft_reset,
    input  logic                parity_done,
    input  logic                low_pkt_valid,
    output logic                detect_add,
    output logic                lfd_state,
    output logic                ld_state,
    output logic                full_state,
    output logic                laf_state,
    output logic                rst_int_reg,
    output logic                write_enb_reg,
    output logic                busy,
    output logic [NUM_DEST-1:0] dest_sel,
    output logic                pkt_dropped
);
    // state              | meaning
    // DECODE_ADDRESS     | idle, waiting for a header byte
    // LOAD_FIRST_DATA    | header written into the selected FIFO
    // LOAD_DATA          | payload bytes streaming in
    // FIFO_FULL_STATE    | selected FIFO full, source stalled
    // LOAD_AFTER_FULL    | retry the byte held during the stall
    // LOAD_PARITY        | parity byte written
    // CHECK_PARITY_ERROR | parity compare, internal reset pulse
    // WAIT_TILL_EMPTY    | selected FIFO still draining a previous packet
    // DROP_PACKET        | packet discarded, source drains with busy low
    typedef enum logic [3:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR,
        WAIT_TILL_EMPTY,
        DROP_PACKET
    } state_t;

    localparam logic [ADDR_W:0]     DEST_LIM  = NUM_DEST[ADDR_W:0];
    localparam int                  TO_LAST_I = (WAIT_TO == 0) ? 0 : WAIT_TO - 1;
    localparam logic [TO_W-1:0]     TO_LAST   = TO_LAST_I[TO_W-1:0];
    localparam logic [NUM_DEST-1:0] ONE_HOT0  = {{(NUM_DEST-1){1'b0}}, 1'b1};

    state_t              state;
    state_t              nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic                addr_vld;
    logic [TO_W-1:0]     to_cnt;
    logic [NUM_DEST-1:0] hdr_onehot;
    logic                hdr_in_range;
    logic                hdr_empty;
    logic                sel_empty;
    logic                sel_soft;
    logic                to_expired;

    assign hdr_onehot   = ONE_HOT0 << data_in;
    assign hdr_in_range = ({1'b0, data_in} < DEST_LIM);
    assign hdr_empty    = |(fifo_empty & hdr_onehot);
    assign dest_sel     = addr_vld ? (ONE_HOT0 << addr_q) : '0;
    // dest_sel is zero without a held address, so these also gate on addr_vld
    assign sel_empty    = |(fifo_empty & dest_sel);
    assign sel_soft     = |(soft_reset & dest_sel);
    assign to_expired   = (WAIT_TO != 0) && (to_cnt == TO_LAST);

    always_comb begin
        nxt = state;
        case (state)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    if (!hdr_in_range)  nxt = DROP_PACKET;
                    else if (hdr_empty) nxt = LOAD_FIRST_DATA;
                    else                nxt = WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: nxt = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       nxt = FIFO_FULL_STATE;
                else if (!pkt_valid) nxt = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) nxt = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        nxt = DECODE_ADDRESS;
                else if (low_pkt_valid) nxt = LOAD_PARITY;
                else                    nxt = LOAD_DATA;
            end
            LOAD_PARITY: nxt = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                if (fifo_full) nxt = FIFO_FULL_STATE;
                else           nxt = DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (sel_empty)       nxt = LOAD_FIRST_DATA;
                else if (to_expired) nxt = DROP_PACKET;
            end
            DROP_PACKET: begin
                if (!pkt_valid) nxt = DECODE_ADDRESS;
            end
            default: nxt = DECODE_ADDRESS;
        endcase
        if (sel_soft) nxt = DECODE_ADDRESS;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= DECODE_ADDRESS;
            addr_q      <= '0;
            addr_vld    <= 1'b0;
            to_cnt      <= '0;
            pkt_dropped <= 1'b0;
        end else begin
            state       <= nxt;
            pkt_dropped <= (nxt == DROP_PACKET) && (state != DROP_PACKET);
            to_cnt      <= (state == WAIT_TILL_EMPTY) ? to_cnt + TO_W'(1) : '0;
            if (nxt == DECODE_ADDRESS) begin
                addr_vld <= 1'b0;
            end else if (state == DECODE_ADDRESS &&
                         (nxt == LOAD_FIRST_DATA || nxt == WAIT_TILL_EMPTY)) begin
                addr_q   <= data_in;
                addr_vld <= 1'b1;
            end
        end
    end

    assign detect_add    = (state == DECODE_ADDRESS);
    assign lfd_state     = (state == LOAD_FIRST_DATA);
    assign ld_state      = (state == LOAD_DATA);
    assign full_state    = (state == FIFO_FULL_STATE);
    assign laf_state     = (state == LOAD_AFTER_FULL);
    assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
    assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                           (state == LOAD_AFTER_FULL);
    assign busy          = (state == LOAD_FIRST_DATA) || (state == FIFO_FULL_STATE) ||
                           (state == LOAD_AFTER_FULL) || (state == LOAD_PARITY) ||
                           (state == CHECK_PARITY_ERROR) || (state == WAIT_TILL_EMPTY);

endmodule

// File: tb/tb_router_fsm_multi.sv
// Bench for router_fsm_multi: a 3-destination instance with an 8-cycle wait timeout and an
// 8-destination instance without timeout, both tracked cycle by cycle by a behavioural model.
module tb_router_fsm_multi;
    localparam int S_DA = 0, S_LFD = 1, S_LD = 2, S_FFS = 3, S_LAF = 4,
                   S_LP = 5, S_CPE = 6, S_WTE = 7, S_DROP = 8;

    typedef struct packed {
        int st;
        int addr;
        bit vld;
        int cnt;
        bit drop;
    } mdl_t;

    logic       clock = 1'b0, resetn = 1'b0;
    logic       pkt_valid = 1'b0, fifo_full = 1'b0, parity_done = 1'b0, low_pkt_valid = 1'b0;
    logic [1:0] din3 = '0;
    logic [2:0] emp3 = '0, sr3 = '0;
    logic [2:0] din8 = '0;
    logic [7:0] emp8 = '0, sr8 = '0;

    logic o3_detect, o3_lfd, o3_ld, o3_full, o3_laf, o3_rst, o3_we, o3_busy, o3_drop;
    logic o8_detect, o8_lfd, o8_ld, o8_full, o8_laf, o8_rst, o8_we, o8_busy, o8_drop;
    logic [2:0] o3_dest;
    logic [7:0] o8_dest;

    mdl_t m3, m8;
    int   n_cmp = 0, n_bad = 0;

    always #5 clock = ~clock;

    router_fsm_multi #(.NUM_DEST(3), .ADDR_W(2), .WAIT_TO(8), .TO_W(16)) dut3 (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(din3),
        .fifo_full(fifo_full), .fifo_empty(emp3), .soft_reset(sr3),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(o3_detect), .lfd_state(o3_lfd), .ld_state(o3_ld), .full_state(o3_full),
        .laf_state(o3_laf), .rst_int_reg(o3_rst), .write_enb_reg(o3_we), .busy(o3_busy),
        .dest_sel(o3_dest), .pkt_dropped(o3_drop));

    router_fsm_multi #(.NUM_DEST(8), .ADDR_W(3), .WAIT_TO(0), .TO_W(16)) dut8 (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(din8),
        .fifo_full(fifo_full), .fifo_empty(emp8), .soft_reset(sr8),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(o8_detect), .lfd_state(o8_lfd), .ld_state(o8_ld), .full_state(o8_full),
        .laf_state(o8_laf), .rst_int_reg(o8_rst), .write_enb_reg(o8_we), .busy(o8_busy),
        .dest_sel(o8_dest), .pkt_dropped(o8_drop));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic mdl_t step(input mdl_t m, input bit pv, input int din, input bit full,
                                  input int empty, input int srst, input bit pd, input bit lpv,
                                  input int n, input int w);
        mdl_t r;
        int   nx;
        r  = m;
        nx = m.st;
        case (m.st)
            S_DA: if (pv) begin
                if (din >= n) nx = S_DROP;
                else begin
                    r.addr = din;
                    r.vld  = 1'b1;
                    nx = (((empty >> din) & 1) != 0) ? S_LFD : S_WTE;
                end
            end
            S_LFD:  nx = S_LD;
            S_LD:   nx = full ? S_FFS : (pv ? S_LD : S_LP);
            S_FFS:  nx = full ? S_FFS : S_LAF;
            S_LAF:  nx = pd ? S_DA : (lpv ? S_LP : S_LD);
            S_LP:   nx = S_CPE;
            S_CPE:  nx = full ? S_FFS : S_DA;
            S_WTE:  if (((empty >> m.addr) & 1) != 0) nx = S_LFD;
                    else if (w != 0 && m.cnt == w - 1) nx = S_DROP;
            S_DROP: nx = pv ? S_DROP : S_DA;
            default: nx = S_DA;
        endcase
        if (m.vld && (((srst >> m.addr) & 1) != 0)) nx = S_DA;
        if (nx == S_DA) r.vld = 1'b0;
        r.cnt  = (m.st == S_WTE) ? m.cnt + 1 : 0;
        r.drop = (nx == S_DROP) && (m.st != S_DROP);
        r.st   = nx;
        return r;
    endfunction

    function automatic logic [8:0] flags(input mdl_t m);
        return {m.st == S_DA, m.st == S_LFD, m.st == S_LD, m.st == S_FFS, m.st == S_LAF,
                m.st == S_CPE, (m.st == S_LD || m.st == S_LP || m.st == S_LAF),
                (m.st inside {S_LFD, S_FFS, S_LAF, S_LP, S_CPE, S_WTE}), m.drop};
    endfunction

    function automatic int dexp(input mdl_t m);
        return m.vld ? (1 << m.addr) : 0;
    endfunction

    function automatic bit in_wte3();
        return o3_busy && !o3_lfd && !o3_full && !o3_laf && !o3_rst && !o3_we;
    endfunction

    task automatic compare_all();
        chk("flags3", 32'({o3_detect, o3_lfd, o3_ld, o3_full, o3_laf, o3_rst, o3_we, o3_busy, o3_drop}),
            32'(flags(m3)));
        chk("dest3", 32'(o3_dest), 32'(dexp(m3)));
        chk("flags8", 32'({o8_detect, o8_lfd, o8_ld, o8_full, o8_laf, o8_rst, o8_we, o8_busy, o8_drop}),
            32'(flags(m8)));
        chk("dest8", 32'(o8_dest), 32'(dexp(m8)));
    endtask

    task automatic tick();
        @(posedge clock);
        m3 = step(m3, pkt_valid, int'(din3), fifo_full, int'(emp3), int'(sr3),
                  parity_done, low_pkt_valid, 3, 8);
        m8 = step(m8, pkt_valid, int'(din8), fifo_full, int'(emp8), int'(sr8),
                  parity_done, low_pkt_valid, 8, 0);
        #1;
        compare_all();
    endtask

    // drops reset between edges so the clear is seen asynchronously
    task automatic async_rst();
        #3;
        resetn = 1'b0;
        #1;
        m3 = '0;
        m8 = '0;
        chk("arst_detect3", 32'(o3_detect), 32'd1);
        chk("arst_dest3", 32'(o3_dest), 32'd0);
        compare_all();
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        int nwe, nwe8, nf, nw;
        m3 = '0;
        m8 = '0;
        #1;
        chk("rst_detect3", 32'(o3_detect), 32'd1);
        compare_all();
        @(negedge clock);
        resetn = 1'b1;

        // T1 + NUM_DEST=8 regression for addr 7
        pkt_valid = 1; din3 = 2'd1; din8 = 3'd7; emp3 = '1; emp8 = '1;
        tick();
        chk("t1_lfd", 32'(o3_lfd), 32'd1);
        chk("t1_dest3", 32'(o3_dest), 32'h2);
        chk("t1_dest8", 32'(o8_dest), 32'h80);
        nwe = 0; nwe8 = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 4) pkt_valid = 0;
            tick();
            if (o3_we) nwe++;
            if (o8_we) nwe8++;
        end
        chk("t1_we_cycles3", 32'(nwe), 32'd5);
        chk("t1_we_cycles8", 32'(nwe8), 32'd5);
        chk("t1_end_da", 32'({o3_detect, o3_dest}), 32'b1000);

        // T2 full stall during LD
        pkt_valid = 1; din3 = 2'd0;
        tick(); tick();
        fifo_full = 1; nf = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) fifo_full = 0;
            tick();
            if (o3_full) nf++;
            if (i == 2) chk("t2_laf_busy", 32'({o3_laf, o3_busy}), 32'b11);
        end
        chk("t2_ffs_cycles", 32'(nf), 32'd2);
        chk("t2_back_ld", 32'({o3_ld, o3_busy}), 32'b10);
        pkt_valid = 0;
        tick(); tick(); tick();

        // T3 out-of-range header
        chk("t3_idle", 32'(o3_detect), 32'd1);
        pkt_valid = 1; din3 = 2'd3; nwe = 0;
        tick();
        chk("t3_drop_pulse", 32'(o3_drop), 32'd1);
        if (o3_we) nwe++;
        tick();
        chk("t3_drop_once", 32'(o3_drop), 32'd0);
        if (o3_we) nwe++;
        pkt_valid = 0;
        tick();
        chk("t3_we_never", 32'(nwe), 32'd0);
        chk("t3_back_da", 32'(o3_detect), 32'd1);

        // T4 wait-till-empty timeout, then early empty
        pkt_valid = 1; din3 = 2'd2; emp3 = 3'b011; nw = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (in_wte3()) nw++;
            else break;
        end
        chk("t4_wte_cycles", 32'(nw), 32'd8);
        chk("t4_timeout_drop", 32'(o3_drop), 32'd1);
        pkt_valid = 0;
        tick();
        pkt_valid = 1; nw = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (in_wte3()) begin
                nw++;
                if (nw == 5) emp3 = 3'b111;
            end else break;
        end
        chk("t4_wte_early", 32'(nw), 32'd5);
        chk("t4_empty_lfd", 32'(o3_lfd), 32'd1);
        pkt_valid = 0;
        tick(); tick(); tick(); tick();

        // T5 soft reset keyed on latched address
        chk("t5_idle", 32'(o3_detect), 32'd1);
        pkt_valid = 1; din3 = 2'd0; emp3 = '1;
        tick(); tick();
        sr3 = 3'b010;
        tick();
        chk("t5_other_ignored", 32'(o3_ld), 32'd1);
        sr3 = 3'b001;
        tick();
        chk("t5_soft_da", 32'({o3_detect, o3_dest}), 32'b1000);
        sr3 = '0; pkt_valid = 0;
        tick();

        // T6 async reset while in FFS
        pkt_valid = 1; din3 = 2'd0;
        tick(); tick();
        fifo_full = 1;
        tick();
        chk("t6_in_ffs", 32'(o3_full), 32'd1);
        async_rst();
        chk("t6_ffs_cleared", 32'(o3_full), 32'd0);
        fifo_full = 0; pkt_valid = 0;

        // randomized lockstep run against the model
        for (int c = 0; c < 3000; c++) begin
            pkt_valid     = ($urandom_range(0, 3) != 0);
            fifo_full     = ($urandom_range(0, 3) == 0);
            parity_done   = ($urandom_range(0, 3) == 0);
            low_pkt_valid = ($urandom_range(0, 3) == 0);
            din3 = 2'($urandom);
            din8 = 3'($urandom);
            emp3 = 3'($urandom);
            emp8 = 8'($urandom);
            sr3  = 3'($urandom) & 3'($urandom) & 3'($urandom) & 3'($urandom);
            sr8  = 8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 199) == 0) async_rst();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
